// File: rtl/note_pkg.sv
// Shared constants and helpers for the note player: the chromatic pitch table,
// the divider half-period calculation and the player state encoding.
package note_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Note frequencies in centihertz, indexed by note code (0 and 13..15 are rests).
    localparam int unsigned F_CHZ [16] = '{
        0,
        26163, 27718, 29366, 31113, 32963, 34923,
        36999, 39200, 41530, 44000, 46616, 49388,
        0, 0, 0
    };

    // Clock cycles per half period of the note; 0 for rests.
    function automatic longint unsigned half_cnt(input longint unsigned clk_hz,
                                                 input logic [3:0] note);
        longint unsigned f;
        f = longint'(F_CHZ[note]);
        if (f == 0) return 0;
        return (clk_hz * 64'd50) / f;
    endfunction

    // Clock cycles per millisecond (MS_DIV = CLK_HZ/1000).
    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // True for note codes that produce a pitch (C4..B4).
    function automatic logic is_pitched(input logic [3:0] note);
        return (note != 4'd0) && (note <= 4'd12);
    endfunction

endpackage

// File: rtl/note_player_tone_divider.sv
// Programmable square-wave divider: toggles tone each time the counter
// reaches limit, then wraps. Holding run low parks it with tone low.
module tone_divider #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic             tone
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    // Next counter/tone value: clear when stopped, toggle and wrap at the limit.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!run) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == limit) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/note_player.sv
// Plays one chromatic note (or rest) for a number of milliseconds, driving a
// 50%-duty square wave and pulsing done when the note ends naturally.
module note_player
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          CNT_W  = 18,
    parameter int          DUR_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    input  logic [DUR_W-1:0] duration_ms,
    output logic             tone,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      MS_DIV  = ms_div(CLK_HZ);
    localparam int               MS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_DIV - 1);

    state_e           state_q, state_d;
    logic [3:0]       note_q, note_d;
    logic [1:0]       oct_q, oct_d;
    logic [DUR_W-1:0] remain_q, remain_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             run;
    logic [CNT_W-1:0] limit;

    // NOTE: half_tbl is elaboration-time constant wiring, not a storage array, so it has no reset.
    logic [CNT_W-1:0] half_tbl [16];
    for (genvar i = 0; i < 16; i++) begin : g_half
        localparam longint unsigned HC = half_cnt(longint'(CLK_HZ), 4'(i));
        assign half_tbl[i] = CNT_W'(HC);
    end

    assign limit = (half_tbl[note_q] >> oct_q) - CNT_W'(1);

    // FSM, millisecond prescaler and remaining-duration counter.
    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        oct_d    = oct_q;
        remain_d = remain_q;
        ms_d     = ms_q;
        run      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    note_d   = note;
                    oct_d    = octave;
                    remain_d = duration_ms;
                    ms_d     = '0;
                    state_d  = (duration_ms != '0) ? PLAY : FINISH;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                    ms_d    = '0;
                end else begin
                    if (ms_q == MS_LAST) begin
                        ms_d     = '0;
                        remain_d = remain_q - DUR_W'(1);
                        if (remain_q == DUR_W'(1)) state_d = FINISH;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end
                // Stopping the divider on the leaving edge forces tone low with busy.
                run = is_pitched(note_q) && (state_d == PLAY);
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Player registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            note_q   <= '0;
            oct_q    <= '0;
            remain_q <= '0;
            ms_q     <= '0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            oct_q    <= oct_d;
            remain_q <= remain_d;
            ms_q     <= ms_d;
        end
    end

    assign busy = (state_q == PLAY);
    assign done = (state_q == FINISH);

    tone_divider #(
        .CNT_W (CNT_W)
    ) u_tone_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .limit (limit),
        .tone  (tone)
    );

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player at CLK_HZ = 1 MHz (1 ms = 1000 cycles).
module tb_note_player;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  note;
    logic [1:0]  octave;
    logic [11:0] duration_ms;
    logic        tone;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Per-window measurements; j counts clock edges since the start edge (j=0 right after it).
    int busy_cnt, tog_cnt, first_tog, min_int, max_int;
    int done_cnt, done_at, idle_tone_hi, tone_hi_cnt;

    note_player #(
        .CLK_HZ (1_000_000),
        .CNT_W  (18),
        .DUR_W  (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .note        (note),
        .octave      (octave),
        .duration_ms (duration_ms),
        .tone        (tone),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents one start request across a single rising edge; returns at sample j=0.
    task automatic issue(input logic [3:0] n, input logic [1:0] o, input logic [11:0] d);
        note        = n;
        octave      = o;
        duration_ms = d;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Samples n cycles on the falling edge; optional disturbances after sample j (-1 = none).
    task automatic measure(input int n, input int inj_at, input int abort_at, input int rst_at);
        logic prev_tone;
        int   last_tog;
        prev_tone = 1'b0;
        last_tog  = 0;
        busy_cnt = 0; tog_cnt = 0; first_tog = -1; min_int = 1 << 30; max_int = -1;
        done_cnt = 0; done_at = -1; idle_tone_hi = 0; tone_hi_cnt = 0;
        for (int j = 0; j < n; j++) begin
            if (busy === 1'b1) busy_cnt++;
            if (tone === 1'b1) tone_hi_cnt++;
            if (busy !== 1'b1 && tone !== 1'b0) idle_tone_hi++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (busy === 1'b1 && tone !== prev_tone) begin
                tog_cnt++;
                if (first_tog < 0) first_tog = j;
                if (j - last_tog < min_int) min_int = j - last_tog;
                if (j - last_tog > max_int) max_int = j - last_tog;
                last_tog = j;
            end
            prev_tone = tone;
            if (j == inj_at) begin
                note = 4'd1; duration_ms = 12'd1; start = 1'b1;
            end
            if (j == inj_at + 1) start = 1'b0;
            if (j == abort_at) abort = 1'b1;
            if (j == abort_at + 1) abort = 1'b0;
            if (j == rst_at) rst_n = 1'b0;
            if (j == rst_at + 2) rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        note = 4'd10; octave = 2'd0; duration_ms = 12'd5;

        // Reset held with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tone", 32'(tone), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_accept", 32'({busy, done}), 0);
        @(negedge clk);

        // A4, octave 0, 5 ms.
        issue(4'd10, 2'd0, 12'd5);
        measure(5010, -1, -1, -1);
        check("a4o0_busy",      busy_cnt, 5000);
        check("a4o0_toggles",   tog_cnt, 4);
        check("a4o0_first",     first_tog, 1136);
        check("a4o0_min_half",  min_int, 1136);
        check("a4o0_max_half",  max_int, 1136);
        check("a4o0_done_cnt",  done_cnt, 1);
        check("a4o0_done_at",   done_at, 5000);
        check("a4o0_idle_tone", idle_tone_hi, 0);

        // A4, octave 1, 2 ms.
        issue(4'd10, 2'd1, 12'd2);
        measure(2010, -1, -1, -1);
        check("a4o1_busy",     busy_cnt, 2000);
        check("a4o1_toggles",  tog_cnt, 3);
        check("a4o1_min_half", min_int, 568);
        check("a4o1_max_half", max_int, 568);
        check("a4o1_done_at",  done_at, 2000);

        // G4, octave 0, 2 ms: one toggle, then truncated.
        issue(4'd8, 2'd0, 12'd2);
        measure(2010, -1, -1, -1);
        check("g4_busy",      busy_cnt, 2000);
        check("g4_toggles",   tog_cnt, 1);
        check("g4_first",     first_tog, 1275);
        check("g4_idle_tone", idle_tone_hi, 0);
        check("g4_done_at",   done_at, 2000);

        // Rests: note 0 and note 14, 3 ms each.
        issue(4'd0, 2'd0, 12'd3);
        measure(3010, -1, -1, -1);
        check("rest0_busy",   busy_cnt, 3000);
        check("rest0_tone",   tone_hi_cnt, 0);
        check("rest0_done",   done_cnt, 1);
        check("rest0_doneat", done_at, 3000);
        issue(4'd14, 2'd2, 12'd3);
        measure(3010, -1, -1, -1);
        check("rest14_busy",   busy_cnt, 3000);
        check("rest14_tone",   tone_hi_cnt, 0);
        check("rest14_doneat", done_at, 3000);

        // Start during PLAY with a different note and duration is ignored.
        issue(4'd10, 2'd0, 12'd2);
        measure(2010, 100, -1, -1);
        check("race_busy",     busy_cnt, 2000);
        check("race_first",    first_tog, 1136);
        check("race_toggles",  tog_cnt, 1);
        check("race_done_at",  done_at, 2000);

        // Zero duration: done immediately, never busy.
        issue(4'd10, 2'd0, 12'd0);
        measure(5, -1, -1, -1);
        check("zero_busy",    busy_cnt, 0);
        check("zero_done",    done_cnt, 1);
        check("zero_done_at", done_at, 0);

        // Start arriving in the FINISH cycle is ignored.
        issue(4'd10, 2'd0, 12'd1);
        measure(1100, 1000, -1, -1);
        check("fin_busy",    busy_cnt, 1000);
        check("fin_done",    done_cnt, 1);
        check("fin_done_at", done_at, 1000);

        // Abort at cycle 1500 of a 4 ms note.
        issue(4'd10, 2'd0, 12'd4);
        measure(4100, -1, 1500, -1);
        check("abort_busy",      busy_cnt, 1501);
        check("abort_done",      done_cnt, 0);
        check("abort_idle_tone", idle_tone_hi, 0);
        check("abort_toggles",   tog_cnt, 1);

        // Reset at cycle 1500 of a 4 ms note, then a normal note.
        issue(4'd10, 2'd0, 12'd4);
        measure(4100, -1, -1, 1500);
        check("rstmid_busy",      busy_cnt, 1501);
        check("rstmid_done",      done_cnt, 0);
        check("rstmid_idle_tone", idle_tone_hi, 0);
        issue(4'd10, 2'd0, 12'd5);
        measure(5010, -1, -1, -1);
        check("after_busy",    busy_cnt, 5000);
        check("after_toggles", tog_cnt, 4);
        check("after_half",    max_int, 1136);
        check("after_done_at", done_at, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Parametrised successor to the fixed-pitch tone dividers used by the song player.
- One block plays any of 12 chromatic notes (C4..B4) shifted up by 0..3 octaves, or a rest, for a programmed duration in milliseconds.
- Outputs a 50%-duty square wave to the buzzer pin and pulses done at the end of the note.
- Sits between the song sequencer (which issues start/note/duration) and the buzzer output.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; must be a multiple of 1000.
- CNT_W, 18, width of the pitch divider counter; must hold HALF_CNT(C4) at the chosen CLK_HZ.
- DUR_W, 12, width of duration_ms; maximum note length is 2^DUR_W-1 ms.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; accepted only when busy=0.
- abort  in  1  stops the current note immediately; has priority over start.
- note  in  4  0 = rest; 1..12 = C4..B4; 13..15 are treated as rest.
- octave  in  2  upward octave shift, 0..3.
- duration_ms  in  DUR_W  note length in ms.
- tone  out  1  square wave output.
- busy  out  1  high while a note or rest is playing.
- done  out  1  one-cycle pulse at natural note end.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous, active-low, on rst_n.
  - While rst_n=0 at a clk edge: tone=0, busy=0, done=0, and all counters and state are cleared.
  - Reset mid-note aborts the note with no done pulse.
- Pitch constants:
  - HALF_CNT(n) = floor(CLK_HZ*50 / F_CHZ(n)), where F_CHZ is the note frequency in centihertz (C4=26163 ... G4=39200, A4=44000, B4=49388).
  - Divider limit = (HALF_CNT(n) >> octave) - 1.
  - tone toggles when the divider reaches the limit; the divider then wraps to 0.
- States: IDLE, PLAY, FINISH.
- IDLE:
  - busy=0 and tone=0.
  - start=1 and abort=0 → latch note, octave and duration_ms.
    - If duration_ms != 0: go to PLAY; busy=1 on the next cycle; divider and ms prescaler are cleared.
    - If duration_ms == 0: go to FINISH directly; busy stays 0.
  - Latched inputs are held for the whole note; input changes during PLAY are ignored.
- PLAY:
  - The ms prescaler counts 0..CLK_HZ/1000-1 and produces a tick on wrap.
  - Each tick decrements the remaining count.
  - The tick that brings the count to 0 moves the block to FINISH.
  - For a rest, the divider does not run and tone stays 0, but duration is counted normally.
  - First tone rising edge occurs limit+1 cycles after busy rises. tone starts at 0.
- FINISH:
  - For one cycle: done=1, busy=0, tone=0, then return to IDLE.
  - A start arriving in the FINISH cycle is ignored.
  - The next start is accepted from IDLE the following cycle.
- Command rules:
  - start while busy=1 is ignored; there is no queueing.
  - abort=1 in PLAY → IDLE next cycle; tone=0, busy=0, no done.
  - abort in IDLE: no effect, and a start in the same cycle is dropped.
- Timing and ranges:
  - Note length = duration_ms*CLK_HZ/1000 cycles of busy, exactly.
  - tone never glitches: it changes only on divider wrap or when forced to 0 at note end.
  - The final half-period may be truncated at note end.

Decomposition:
- Package note_pkg holds:
  - the F_CHZ centihertz table indexed by note code;
  - a constant function half_cnt(clk_hz, note) returning HALF_CNT;
  - a state enum {IDLE, PLAY, FINISH};
  - the constant MS_DIV = CLK_HZ/1000.
- One sub-module, tone_divider (CNT_W, clk, rst_n, run, limit, tone), generalises the fixed-divider blocks.
  - When run=0, it clears its counter and forces tone=0.
- Top-level note_player holds the FSM, ms prescaler and duration counter.

Test Plan:
- Sim settings: CLK_HZ=1_000_000, so one ms = 1000 cycles.
- Reset: hold rst_n=0 for 3 cycles with start=1 → tone=0, busy=0, done=0 throughout; start is not accepted.
- A4, octave 0, duration 5: start → busy high from the next cycle for exactly 5000 cycles; tone toggles every 1136 cycles (4 toggles); done pulses once, 5001 cycles after start.
- A4, octave 1, duration 2: tone toggles every 568 cycles; G4, octave 0, gives a 1275-cycle half-period; busy lasts 2000 cycles.
- Rest (note=0, then note=14), duration 3: tone stays 0; busy lasts 3000 cycles; done pulses.
- Control races:
  - start during PLAY with a different note → ignored, pitch unchanged.
  - duration 0 → done on the cycle after start, busy never high.
  - start in the FINISH cycle → ignored.
- Abort and reset mid-note:
  - abort at cycle 1500 of a 4 ms note → busy and tone low the next cycle, no done pulse.
  - rst_n low mid-note → same result, and a new note after release behaves as in the A4, octave 0 scenario.
